// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: E-stage <-> multiply/divide unit bundle.
// The master side (E stage / forwarding logic) issues ops and reads HI/LO.
// The slave side (mdu_hilo) owns HI/LO and reports busy.
interface mdu_hilo_if;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        sel_hi;
  logic        busy;
  logic [31:0] mdu_out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, mdu_op, A, B, req, sel_hi,
    input  busy, mdu_out, HI, LO
  );

  modport slave (
    input  start, mdu_op, A, B, req, sel_hi,
    output busy, mdu_out, HI, LO
  );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with HI/LO registers (E stage).
// The result is computed at the accept edge and held in tmp; busy then counts
// down the modelled latency before {HI,LO} is committed.
// Optional feature: define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU.
//
// state | meaning
// IDLE  | ready to accept; MTHI/MTLO complete here with zero latency
// RUN   | op in flight, cnt counts down to the commit edge
module mdu_hilo #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_hilo_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      tmp;
  logic             div_zero;
  logic [31:0]      hi;
  logic [31:0]      lo;

  logic        op_valid;
  logic        accept;
  logic        mul_signed;
  logic        div_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  // Op decode: which codes are real ops in this build.
  always_comb begin
    op_valid = 1'b0;
    case (bus.mdu_op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: op_valid = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:                 op_valid = 1'b1;
`endif
      default:                                              op_valid = 1'b0;
    endcase
  end

  assign accept = bus.start && (state == IDLE) && !bus.req && op_valid;

  // Shared 64-bit multiplier; signedness is just the operand extension.
  always_comb begin
    mul_signed = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MADD) ||
                 (bus.mdu_op == OP_MSUB);
    a_ext = {{32{mul_signed & bus.A[31]}}, bus.A};
    b_ext = {{32{mul_signed & bus.B[31]}}, bus.B};
    prod  = a_ext * b_ext;
  end

  // Shared unsigned divider on magnitudes; signs are restored afterwards so the
  // quotient truncates toward zero and the remainder follows the dividend.
  // A zero divisor is replaced by 1 only to keep the datapath defined; that
  // result is never committed.
  always_comb begin
    div_signed = (bus.mdu_op == OP_DIV);
    dvd_mag = (div_signed && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
    dvs_mag = (div_signed && bus.B[31]) ? (32'd0 - bus.B) : bus.B;
    if (dvs_mag == 32'd0) begin
      dvs_mag = 32'd1;
    end
    q_mag = dvd_mag / dvs_mag;
    r_mag = dvd_mag % dvs_mag;
    quo = (div_signed && (bus.A[31] ^ bus.B[31])) ? (32'd0 - q_mag) : q_mag;
    rem = (div_signed && bus.A[31]) ? (32'd0 - r_mag) : r_mag;
  end

  // Control FSM plus HI/LO/tmp/cnt registers; reset discards any in-flight op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      tmp      <= '0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (bus.mdu_op)
              OP_MTHI: hi <= bus.A;
              OP_MTLO: lo <= bus.A;
              OP_MULT, OP_MULTU: begin
                tmp      <= prod;
                div_zero <= 1'b0;
                cnt      <= CNT_W'(MUL_LAT);
                state    <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                tmp      <= {rem, quo};
                div_zero <= (bus.B == 32'd0);
                cnt      <= CNT_W'(DIV_LAT);
                state    <= RUN;
              end
`ifdef MDU_MADD_EN
              OP_MADD, OP_MADDU: begin
                tmp      <= {hi, lo} + prod;
                div_zero <= 1'b0;
                cnt      <= CNT_W'(MUL_LAT);
                state    <= RUN;
              end
              OP_MSUB, OP_MSUBU: begin
                tmp      <= {hi, lo} - prod;
                div_zero <= 1'b0;
                cnt      <= CNT_W'(MUL_LAT);
                state    <= RUN;
              end
`endif
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            if (!div_zero) begin
              hi <= tmp[63:32];
              lo <= tmp[31:0];
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.HI      = hi;
  assign bus.LO      = lo;
  assign bus.mdu_out = bus.sel_hi ? hi : lo;

endmodule
